// File: rtl/cnn_window_gen_pkg.sv
// Shared pixel width and FSM state encoding for the 3x3 window generator.
package cnn_window_gen_pkg;

  localparam int unsigned WIDTH = 9;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/cnn_window_gen_if.sv
// Pixel stream in, 3x3 neighbourhood stream out.
interface cnn_window_gen_if
  import cnn_window_gen_pkg::*;
#(
  parameter int unsigned DW = WIDTH
);

  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] W1, W2, W3, W4, W5, W6, W7, W8, W9;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sof;
  logic                 out_eof;
  logic                 busy;

  // Window generator side
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, W1, W2, W3, W4, W5, W6, W7, W8, W9,
    output out_valid, out_sof, out_eof, busy
  );

  // Frame source / cell side
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, W1, W2, W3, W4, W5, W6, W7, W8, W9,
    input  out_valid, out_sof, out_eof, busy
  );

endinterface

// File: rtl/cnn_line_buf.sv
// DEPTH-deep shift delay line; o_data is the sample shifted in DEPTH enables ago.
module cnn_line_buf
  import cnn_window_gen_pkg::*;
#(
  parameter int unsigned DW    = WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_data,
  output logic signed [DW-1:0] o_data
);

  logic signed [DW-1:0] r_mem [DEPTH];

  // Shift one position per enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_en) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < int'(DEPTH); i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_data = r_mem[DEPTH-1];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster-order pixel stream to zero-padded 3x3 neighbourhoods, one per pixel.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int unsigned DW    = WIDTH,
  parameter int unsigned IMG_W = 4,
  parameter int unsigned IMG_H = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  cnn_window_gen_if.slave  io_win
);

  localparam int unsigned N      = IMG_W * IMG_H;
  localparam int unsigned K_LAST = N + IMG_W;
  localparam int unsigned C_OFS  = IMG_W + 1;
  localparam int unsigned K_W    = $clog2(K_LAST + 1);
  localparam int unsigned COL_W  = $clog2(IMG_W);
  localparam int unsigned ROW_W  = $clog2(IMG_H);

  logic [0:0]           r_state, w_state_nxt;
  logic [K_W-1:0]       r_k, w_k_nxt;
  logic [COL_W-1:0]     r_ccol, w_ccol_nxt;
  logic [ROW_W-1:0]     r_crow, w_crow_nxt;
  logic signed [DW-1:0] r_win [3][2];
  logic signed [DW-1:0] r_w [9];
  logic                 r_valid, r_sof, r_eof;

  logic                 w_slot_free, w_advance, w_emit;
  logic                 w_row_top, w_row_bot, w_col_lft, w_col_rgt;
  logic signed [DW-1:0] w_pix, w_lb0, w_lb1;
  logic signed [DW-1:0] w_col [3];
  logic signed [DW-1:0] w_tap [9];

  assign w_slot_free     = !r_valid || io_win.out_ready;
  assign io_win.in_ready = (r_state == ST_RUN) && w_slot_free;
  assign w_advance       = (r_state == ST_RUN) ? (io_win.in_valid && w_slot_free) : w_slot_free;
  assign w_pix           = (r_state == ST_RUN) ? io_win.in_data : '0;
  // k never exceeds K_LAST, so only the lower bound of the centre range needs testing
  assign w_emit          = (r_k >= K_W'(C_OFS));

  assign w_row_top = (r_crow == '0);
  assign w_row_bot = (r_crow == ROW_W'(IMG_H - 1));
  assign w_col_lft = (r_ccol == '0);
  assign w_col_rgt = (r_ccol == COL_W'(IMG_W - 1));

  // Row r-1 and row r delay lines
  cnn_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (
    .clk(clk), .rst_n(rst_n), .i_en(w_advance), .i_data(w_pix), .o_data(w_lb0)
  );
  cnn_line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .i_en(w_advance), .i_data(w_lb0), .o_data(w_lb1)
  );

  assign w_col[0] = w_lb1;
  assign w_col[1] = w_lb0;
  assign w_col[2] = w_pix;

  // Post-shift window with border taps forced to zero
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      w_tap[r*3]     = r_win[r][0];
      w_tap[r*3 + 1] = r_win[r][1];
      w_tap[r*3 + 2] = w_col[r];
    end
    if (w_row_top) begin
      w_tap[0] = '0; w_tap[1] = '0; w_tap[2] = '0;
    end
    if (w_row_bot) begin
      w_tap[6] = '0; w_tap[7] = '0; w_tap[8] = '0;
    end
    if (w_col_lft) begin
      w_tap[0] = '0; w_tap[3] = '0; w_tap[6] = '0;
    end
    if (w_col_rgt) begin
      w_tap[2] = '0; w_tap[5] = '0; w_tap[8] = '0;
    end
  end

  // Next state: advance counter, RUN/FLUSH and centre position
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_ccol_nxt  = r_ccol;
    w_crow_nxt  = r_crow;
    if (w_advance) begin
      w_k_nxt = r_k + K_W'(1);
      case (r_state)
        ST_RUN: begin
          if (r_k == K_W'(N - 1)) w_state_nxt = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (r_k == K_W'(K_LAST)) begin
            w_k_nxt     = '0;
            w_state_nxt = ST_RUN;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
      if (w_emit) begin
        if (w_col_rgt) begin
          w_ccol_nxt = '0;
          w_crow_nxt = w_row_bot ? '0 : r_crow + ROW_W'(1);
        end else begin
          w_ccol_nxt = r_ccol + COL_W'(1);
        end
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_k     <= '0;
      r_ccol  <= '0;
      r_crow  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_ccol  <= w_ccol_nxt;
      r_crow  <= w_crow_nxt;
    end
  end

  // Two stored window columns; the newest column is taken live from the line buffers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= '0;
        r_win[r][1] <= '0;
      end
    end else if (w_advance) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= w_col[r];
      end
    end
  end

  // Output window register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
      for (int i = 0; i < 9; i++) r_w[i] <= '0;
    end else if (w_advance && w_emit) begin
      r_valid <= 1'b1;
      r_sof   <= w_row_top && w_col_lft;
      r_eof   <= w_row_bot && w_col_rgt;
      for (int i = 0; i < 9; i++) r_w[i] <= w_tap[i];
    end else if (w_slot_free) begin
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eof   <= 1'b0;
    end
  end

  assign io_win.W1        = r_w[0];
  assign io_win.W2        = r_w[1];
  assign io_win.W3        = r_w[2];
  assign io_win.W4        = r_w[3];
  assign io_win.W5        = r_w[4];
  assign io_win.W6        = r_w[5];
  assign io_win.W7        = r_w[6];
  assign io_win.W8        = r_w[7];
  assign io_win.W9        = r_w[8];
  assign io_win.out_valid = r_valid;
  assign io_win.out_sof   = r_sof;
  assign io_win.out_eof   = r_eof;
  assign io_win.busy      = (r_k != '0) || (r_state == ST_FLUSH) || r_valid;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: frame-level neighbourhood model vs DUT windows.
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int unsigned DW = WIDTH;
  localparam int IMG_W = 4;
  localparam int IMG_H = 3;
  localparam int N     = IMG_W * IMG_H;

  typedef int frame_t [N];
  typedef struct {
    int w [9];
    bit sof;
    bit eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   fails = 0;
  int   win_seen = 0;
  int   hold_checks = 0;
  bit   force_low = 1'b0;
  bit   rand_ready = 1'b0;
  exp_t exp_q [$];

  cnn_window_gen_if #(.DW(DW)) bus ();

  cnn_window_gen #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .rst_n(rst_n), .io_win(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic read_taps(output int t [9]);
    t[0] = int'(bus.W1); t[1] = int'(bus.W2); t[2] = int'(bus.W3);
    t[3] = int'(bus.W4); t[4] = int'(bus.W5); t[5] = int'(bus.W6);
    t[6] = int'(bus.W7); t[7] = int'(bus.W8); t[8] = int'(bus.W9);
  endtask

  // Reference: every pixel's zero-padded 3x3 neighbourhood, raster order
  task automatic push_frame(input frame_t f);
    exp_t e;
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            rr = r + dr;
            cc = c + dc;
            e.w[(dr + 1) * 3 + dc + 1] =
              (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W) ? f[rr * IMG_W + cc] : 0;
          end
        end
        e.sof = (r == 0) && (c == 0);
        e.eof = (r == IMG_H - 1) && (c == IMG_W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // out_ready driver
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (force_low)       bus.out_ready = 1'b0;
      else if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      else                 bus.out_ready = 1'b1;
    end
  end

  // Monitor: window scoreboard, hold stability, in_ready under stall
  initial begin
    int   got [9];
    int   prev_w [9];
    bit   prev_sof, prev_eof, prev_stall, ok;
    exp_t e;
    prev_stall = 1'b0;
    prev_sof = 1'b0;
    prev_eof = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        read_taps(got);
        if (prev_stall) begin
          ok = bus.out_valid && (bus.out_sof == prev_sof) && (bus.out_eof == prev_eof);
          for (int i = 0; i < 9; i++) if (got[i] != prev_w[i]) ok = 1'b0;
          checks++;
          hold_checks++;
          if (!ok) begin
            fails++;
            $display("FAIL hold: valid=%0b taps=%p, expected valid=1 taps=%p", bus.out_valid, got, prev_w);
          end
        end
        if (bus.out_valid && !bus.out_ready) begin
          checks++;
          if (bus.in_ready) begin
            fails++;
            $display("FAIL in_ready_during_stall: got %0b expected 0", bus.in_ready);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          win_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_window: got taps=%p with no window expected", got);
          end else begin
            e = exp_q.pop_front();
            ok = (bus.out_sof == e.sof) && (bus.out_eof == e.eof);
            for (int i = 0; i < 9; i++) if (got[i] != e.w[i]) ok = 1'b0;
            if (!ok) begin
              fails++;
              $display("FAIL window %0d: got taps=%p sof=%0b eof=%0b, expected taps=%p sof=%0b eof=%0b",
                       win_seen, got, bus.out_sof, bus.out_eof, e.w, e.sof, e.eof);
            end
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_w     = got;
        prev_sof   = bus.out_sof;
        prev_eof   = bus.out_eof;
      end
    end
  end

  task automatic check_idle(input string tag);
    int t [9];
    bit ok;
    read_taps(t);
    ok = !bus.out_valid && !bus.out_sof && !bus.out_eof && !bus.busy && bus.in_ready;
    for (int i = 0; i < 9; i++) if (t[i] != 0) ok = 1'b0;
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: valid=%0b sof=%0b eof=%0b busy=%0b in_ready=%0b taps=%p, expected 0 0 0 0 1 with zero taps",
               tag, bus.out_valid, bus.out_sof, bus.out_eof, bus.busy, bus.in_ready, t);
    end
  endtask

  // Entered shortly after a rising edge; returns shortly after the accepting edge
  task automatic send_pixel(input int v, input int gap_pct, output int stalls);
    bit acc;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_data  = DW'(v);
    bus.in_valid = 1'b1;
    stalls = 0;
    acc = 1'b0;
    for (int t = 0; t < 400 && !acc; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: pixel %0d not accepted within 400 cycles", v);
    end
  endtask

  task automatic send_frame(input frame_t f, input int gap_pct, input bit keep_valid,
                            output int first_stall);
    int st;
    push_frame(f);
    first_stall = 0;
    for (int i = 0; i < N; i++) begin
      send_pixel(f[i], gap_pct, st);
      if (i == 0) first_stall = st;
    end
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int exp_count, input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.out_valid || bus.busy) && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 1000) begin
      checks++;
      fails++;
      $display("FAIL %s drain_timeout: %0d windows still expected", tag, exp_q.size());
    end
    checks++;
    if (win_seen != exp_count) begin
      fails++;
      $display("FAIL %s window_count: got %0d expected %0d", tag, win_seen, exp_count);
    end
    checks++;
    if (bus.busy) begin
      fails++;
      $display("FAIL %s busy_after_frame: got 1 expected 0", tag);
    end
    win_seen = 0;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = int'($urandom_range(0, 511)) - 256;
    return f;
  endfunction

  initial begin
    frame_t f, f2;
    int     st;
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #2;
    rst_n = 1'b0;
    #10;
    check_idle("reset_state");
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame 1..12
    for (int i = 0; i < N; i++) f[i] = i + 1;
    send_frame(f, 0, 1'b0, st);
    drain(12, "ramp");

    // Consumer stall mid-frame
    hold_checks = 0;
    f = rand_frame();
    fork
      send_frame(f, 0, 1'b0, st);
      begin
        repeat (8) @(posedge clk);
        force_low = 1'b1;
        @(negedge clk);
        checks++;
        if (!bus.busy) begin
          fails++;
          $display("FAIL busy_mid_frame: got 0 expected 1");
        end
        repeat (4) @(posedge clk);
        force_low = 1'b0;
      end
    join
    drain(12, "backpressure");
    checks++;
    if (hold_checks == 0) begin
      fails++;
      $display("FAIL stall_observed: got %0d held cycles expected at least 1", hold_checks);
    end

    // Extreme values at row ends
    f = rand_frame();
    f[IMG_W - 1]     = -256;
    f[2 * IMG_W - 1] = 255;
    f[3 * IMG_W - 1] = -1;
    f[IMG_W]         = -256;
    send_frame(f, 0, 1'b0, st);
    drain(12, "negative");

    // Reset partway through a frame
    f = rand_frame();
    push_frame(f);
    for (int i = 0; i < 7; i++) send_pixel(f[i], 0, st);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("reset_mid_frame");
    exp_q.delete();
    win_seen = 0;
    #14;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) f[i] = 21 + i;
    send_frame(f, 0, 1'b0, st);
    drain(12, "after_reset");

    // Back-to-back frames, in_valid held high
    f  = rand_frame();
    f2 = rand_frame();
    send_frame(f, 0, 1'b1, st);
    send_frame(f2, 0, 1'b0, st);
    checks++;
    if (st != IMG_W + 1) begin
      fails++;
      $display("FAIL flush_stall_cycles: got %0d expected %0d", st, IMG_W + 1);
    end
    drain(24, "back_to_back");

    // Random gaps and random consumer readiness
    rand_ready = 1'b1;
    f = rand_frame();
    send_frame(f, 30, 1'b1, st);
    f = rand_frame();
    send_frame(f, 30, 1'b0, st);
    repeat (3) @(posedge clk);
    #1;
    f = rand_frame();
    send_frame(f, 30, 1'b0, st);
    drain(36, "random");
    rand_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Streams one raster-order image (signed `WIDTH`-bit pixels) and emits, per pixel, the 3x3 zero-padded neighbourhood centred on it.
- Drives a CNN cell's U1..U9 (input) or Y1..Y9 (state) neighbour ports. Window positions are row-major: W1 top-left, W5 centre, W9 bottom-right.
- Sits between the frame source and the one-cell datapath, and produces the neighbourhood bus that the cell consumes.

Parameters:
- DW, `WIDTH` (9): pixel width, signed two's complement.
- IMG_W, 4: pixels per row, minimum 3.
- IMG_H, 3: rows per frame, minimum 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  DW  signed pixel.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- W1..W9  out  DW each  signed window taps, registered.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_sof  out  1  current window is centred at (0,0).
- out_eof  out  1  current window is centred at (IMG_H-1, IMG_W-1).
- busy  out  1  frame in progress (k != 0 or FLUSH or out_valid).

Behaviour:
- **Reset.** Asynchronous, active-low. Clears W1..W9, out_valid, out_sof, out_eof, all counters, and the window registers, and returns to RUN. Line-buffer contents need not be cleared.
- **Reset mid-frame.** Discards the partial frame. The next accepted pixel is treated as (0,0).
- **States.**
  - RUN accepts real pixels.
  - FLUSH injects zero pad pixels without consuming input.
- **Advance counter.** k counts advances within the frame. N = IMG_W*IMG_H.
  - RUN: an advance occurs on an edge with in_valid && in_ready and shifts in_data in. At k = N-1, go to FLUSH.
  - FLUSH: an advance occurs on an edge where the output slot is free, and shifts in 0. After pad advance k = N+IMG_W, set k = 0 and return to RUN.
- **Output slot.** Free when !out_valid || out_ready.
- **in_ready.** (state == RUN) && slot free. Combinational, with no dependency on in_valid.
- **Window storage.**
  - Two delay lines of IMG_W pixels (rows r-1 and r) feed a 3x3 register window.
  - All of these shift only on an advance.
- **Window emission.**
  - Centre index c = k - (IMG_W+1).
  - When 0 <= c < N, the advance also loads W1..W9 and sets out_valid on the same edge.
  - Otherwise out_valid is cleared if out_ready.
  - Result: first out_valid is asserted in the cycle after pixel index IMG_W+1 is accepted. Steady-state throughput is 1 window per cycle.
- **Hold.** While out_valid && !out_ready, W*, out_sof and out_eof are held stable and no advance occurs.
- **Border masking.** Uses the centre row and column counters and forces taps to 0:
  - row 0: W1..W3
  - row IMG_H-1: W7..W9
  - col 0: W1, W4, W7 (suppresses wrap from the previous row)
  - col IMG_W-1: W3, W6, W9
  - Masks combine; a corner zeroes 5 taps.
- **Arithmetic.** Values pass through unmodified; there is no sign extension and no saturation.
- **Back-to-back frames.** Pixels of the next frame are stalled (in_ready = 0) during FLUSH. The new frame starts with k = 0, and stale line-buffer data is masked by the row-0 rule.
- **Flags.** out_sof is asserted only with c = 0; out_eof only with c = N-1. Both qualify out_valid.

Decomposition:
- The shared defines file carries `WIDTH`, plus localparams for the state encoding (RUN = 0, FLUSH = 1).
- One sub-module, cnn_line_buf: a DW-wide, IMG_W-deep shift delay line with a shift enable. It is instantiated twice.
- Counters, mask logic, the FSM and the output register stay in cnn_window_gen.

Test Plan:
1. **First window.** IMG_W=4, IMG_H=3, pixels 1..12, out_ready=1.
   - First out_valid appears one cycle after pixel 6 is accepted.
   - W1..W9 = 0,0,0,0,1,2,0,5,6, with out_sof=1.
2. **Interior window and frame end.** Same frame as scenario 1.
   - Window 6 = 1,2,3,5,6,7,9,10,11.
   - Window 12 = 7,8,0,11,12,0,0,0,0, with out_eof=1.
   - Exactly 12 windows are produced.
   - in_ready = 0 for the 5 flush cycles.
3. **Backpressure.** Hold out_ready=0 for 4 cycles mid-frame.
   - W* stay stable.
   - in_ready stays 0.
   - No pixel is lost or duplicated: the window sequence equals the unstalled run.
4. **Negative pixels and wrap masking.** Pixels -256, 255, -1 at row ends.
   - Values are reproduced bit-exact.
   - Window centred at (1,0) has W1, W4, W7 = 0, not the previous row's last pixel.
5. **Reset mid-frame.** Assert rst_n=0 after pixel 7, asynchronous to clk.
   - out_valid drops immediately.
   - After release, a fresh frame 21..32 yields a first window of 0,0,0,0,21,22,0,25,26.
6. **Back-to-back frames.** Two frames with in_valid held high.
   - Second frame's first window has W1..W3 = 0 (no stale data).
   - Total windows = 24.
